// File: rtl/mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_unit : MEM-stage initiator turning a load/store into one data-memory
// transaction.  Rev 1.0
// ----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic        i_req_load,
  input  logic        i_req_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_store_data,
  output logic        o_data_mem_read,
  output logic        o_data_mem_write,
  output logic [31:0] o_data_mem_address,
  output logic [31:0] o_data_mem_wdata,
  output logic [3:0]  o_data_mem_byte_enable,
  input  logic        i_data_mem_resp,
  input  logic [31:0] i_data_mem_rdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_mdrreg_out,
  output logic        o_misalign_err,
  output logic        o_timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] c_LAST_WAIT  = 32'(WAIT_LIMIT - 1);
  localparam bit          c_TIMEOUT_EN = (WAIT_LIMIT != 0);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_count;
  logic [1:0]  w_off;
  logic [1:0]  w_size;
  logic        w_req;
  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_accept;
  logic        w_reject;
  logic        w_resp;
  logic        w_timeout;
  logic        w_unused;

  assign w_off    = i_req_addr[1:0];
  assign w_size   = i_req_funct3[1:0];
  assign w_req    = i_req_valid & (i_req_load | i_req_store);
  // Sign/zero selection (funct3[2]) belongs to writeback, not to this stage.
  assign w_unused = i_req_funct3[2];

  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = 32'd0;
    case (w_size)
      2'b00: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{i_req_store_data[7:0]}};
      end
      2'b01: begin
        w_legal = ~w_off[0];
        w_be    = 4'b0011 << {w_off[1], 1'b0};
        w_wdata = {2{i_req_store_data[15:0]}};
      end
      2'b10: begin
        w_legal = (w_off == 2'b00);
        w_be    = 4'b1111;
        w_wdata = i_req_store_data;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
    if (i_req_load) begin
      w_wdata = 32'd0;
    end
  end

  always_comb begin
    w_next    = r_state;
    o_stall   = 1'b0;
    o_done    = 1'b0;
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    w_resp    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && !rst) begin
          if (w_legal) begin
            w_accept = 1'b1;
            o_stall  = 1'b1;
            w_next   = S_ACCESS;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        o_stall = 1'b1;
        // A response arriving on the limit cycle still completes normally.
        if (i_data_mem_resp) begin
          w_resp = 1'b1;
          w_next = S_DONE;
        end else if (c_TIMEOUT_EN && (r_count == c_LAST_WAIT)) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data_mem_read        <= 1'b0;
      o_data_mem_write       <= 1'b0;
      o_data_mem_address     <= 32'd0;
      o_data_mem_wdata       <= 32'd0;
      o_data_mem_byte_enable <= 4'b0000;
      o_mdrreg_out           <= 32'd0;
      o_misalign_err         <= 1'b0;
      o_timeout_err          <= 1'b0;
      r_count                <= 32'd0;
    end else begin
      o_misalign_err <= w_reject;
      o_timeout_err  <= w_timeout;
      if (w_accept) begin
        o_data_mem_address     <= {i_req_addr[31:2], 2'b00};
        o_data_mem_byte_enable <= w_be;
        o_data_mem_wdata       <= w_wdata;
        o_data_mem_read        <= i_req_load;
        o_data_mem_write       <= i_req_store & ~i_req_load;
        r_count                <= 32'd0;
      end else if (r_state == S_ACCESS) begin
        r_count <= r_count + 32'd1;
        if (w_resp || w_timeout) begin
          o_data_mem_read  <= 1'b0;
          o_data_mem_write <= 1'b0;
          if (w_resp && o_data_mem_read) begin
            o_mdrreg_out <= i_data_mem_rdata;
          end
        end
      end else if (r_state == S_DONE) begin
        r_count <= 32'd0;
      end
    end
  end

endmodule
`default_nettype wire
